// File: rtl/testpattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// testpattern_gen_pkg
// Shared definitions for the test pattern generator:
//   - mode_e        : pattern encodings MODE_BARS..MODE_BOX
//   - bar_flags()   : on/off flags of the 8 colour bars (scaled to full-scale
//                     channels by the user)
//   - tp_clog2()    : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package testpattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_BOX      = 2'd3
    } mode_e;

    // Bar colour as {r,g,b} on/off flags, left to right:
    // white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_flags(input logic [2:0] idx);
        logic [2:0] f;
        case (idx)
            3'd0:    f = 3'b111;
            3'd1:    f = 3'b110;
            3'd2:    f = 3'b011;
            3'd3:    f = 3'b010;
            3'd4:    f = 3'b101;
            3'd5:    f = 3'b100;
            3'd6:    f = 3'b001;
            default: f = 3'b000;
        endcase
        return f;
    endfunction

    // Smallest r with 2**r >= value (value >= 1).
    function automatic int tp_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/testpattern_gen_if.sv
// -----------------------------------------------------------------------------
// testpattern_gen_if
// Bundle between the VGA timing driver (master) and the pattern generator
// (slave).
//   ctr_h, ctr_v   driver counters              master -> slave
//   mode_next      one-cycle "next pattern" req master -> slave
//   r/g/b_out      registered pixel colour      slave  -> master
//   mode           active pattern               slave  -> master
//   frame_ctr      completed frame count        slave  -> master
//
// Handshake: there is no valid/ready pair. The counters are taken as valid on
// every clock and the generator always accepts them; it answers one clock
// later for the position the driver will then be showing. mode_next is
// honoured on any cycle it is high.
// -----------------------------------------------------------------------------
interface testpattern_gen_if #(
    parameter int CTR_H_W     = 11,
    parameter int CTR_V_W     = 10,
    parameter int COLOR_DEPTH = 8
);
    logic [CTR_H_W-1:0]     ctr_h;
    logic [CTR_V_W-1:0]     ctr_v;
    logic                   mode_next;
    logic [COLOR_DEPTH-1:0] r_out;
    logic [COLOR_DEPTH-1:0] g_out;
    logic [COLOR_DEPTH-1:0] b_out;
    logic [1:0]             mode;
    logic [15:0]            frame_ctr;

    modport master (
        output ctr_h, ctr_v, mode_next,
        input  r_out, g_out, b_out, mode, frame_ctr
    );

    modport slave (
        input  ctr_h, ctr_v, mode_next,
        output r_out, g_out, b_out, mode, frame_ctr
    );
endinterface

// File: rtl/testpattern_gen_box.sv
// -----------------------------------------------------------------------------
// testpattern_gen_box
// Bouncing box position. On each i_fb strobe the box steps one pixel in x and
// one line in y. When it sits on an edge while moving towards it, the
// direction flips and the coordinate holds for that frame.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_fb            frame-boundary strobe (one cycle per frame)
//   o_bx, o_by      top-left corner of the box in active coordinates
// -----------------------------------------------------------------------------
module testpattern_gen_box
    import testpattern_gen_pkg::*;
#(
    parameter int VGA_WIDTH  = 1024,
    parameter int VGA_HEIGHT = 768,
    parameter int BOX_SIZE   = 64
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_fb,
    output logic [tp_clog2(VGA_WIDTH)-1:0]      o_bx,
    output logic [tp_clog2(VGA_HEIGHT)-1:0]     o_by
);
    localparam int XW = tp_clog2(VGA_WIDTH);
    localparam int YW = tp_clog2(VGA_HEIGHT);
    localparam logic [XW-1:0] BX_MAX = XW'(VGA_WIDTH - BOX_SIZE);
    localparam logic [YW-1:0] BY_MAX = YW'(VGA_HEIGHT - BOX_SIZE);

    logic [XW-1:0] r_bx;
    logic [YW-1:0] r_by;
    logic          r_dx_neg;  // 1: moving left
    logic          r_dy_neg;  // 1: moving up

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bx     <= '0;
            r_by     <= '0;
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b0;
        end else if (i_fb) begin
            if (!r_dx_neg) begin
                if (r_bx == BX_MAX) r_dx_neg <= 1'b1;
                else                r_bx     <= r_bx + XW'(1);
            end else begin
                if (r_bx == '0)     r_dx_neg <= 1'b0;
                else                r_bx     <= r_bx - XW'(1);
            end

            if (!r_dy_neg) begin
                if (r_by == BY_MAX) r_dy_neg <= 1'b1;
                else                r_by     <= r_by + YW'(1);
            end else begin
                if (r_by == '0)     r_dy_neg <= 1'b0;
                else                r_by     <= r_by - YW'(1);
            end
        end
    end

    assign o_bx = r_bx;
    assign o_by = r_by;
endmodule

// File: rtl/testpattern_gen.sv
// -----------------------------------------------------------------------------
// testpattern_gen
// Pixel source for the VGA timing driver. Looks one position ahead of the
// driver counters, picks a colour from the active pattern and registers it,
// so the RGB on the outputs lines up with the driver's counters on the next
// clock. Pattern changes and box animation happen only at the frame
// boundary (last counter state of the frame).
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   pix          testpattern_gen_if.slave: ctr_h/ctr_v/mode_next in,
//                r_out/g_out/b_out/mode/frame_ctr out
// Build option:
//   TESTPATTERN_AUTO_CYCLE_EN  when defined, a frame counter requests the next
//                              pattern every AUTO_FRAMES frames in addition to
//                              mode_next.
// -----------------------------------------------------------------------------
module testpattern_gen
    import testpattern_gen_pkg::*;
#(
`ifdef TESTPATTERN_AUTO_CYCLE_EN
    parameter int AUTO_FRAMES  = 120,
`endif
    parameter int COLOR_DEPTH  = 8,
    parameter int VGA_WIDTH    = 1024,
    parameter int VGA_HEIGHT   = 768,
    parameter int H_ADDR_START = 304,
    parameter int V_ADDR_START = 38,
    parameter int H_CNT        = 1328,
    parameter int V_CNT        = 806,
    parameter int BOX_SIZE     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    testpattern_gen_if.slave  pix
);
    localparam int HW         = tp_clog2(H_CNT);
    localparam int VW         = tp_clog2(V_CNT);
    localparam int XW         = tp_clog2(VGA_WIDTH);
    localparam int YW         = tp_clog2(VGA_HEIGHT);
    localparam int GRAD_SHIFT = XW - COLOR_DEPTH;
    localparam logic [COLOR_DEPTH-1:0] FULL      = '1;
    localparam logic [COLOR_DEPTH-1:0] DARK_BLUE = FULL >> 2;

    // ---------------------------------------------------------------
    // Lookahead position: where the driver will be on the next clock
    // ---------------------------------------------------------------
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_fb;
    logic [HW-1:0] w_h_la;
    logic [VW-1:0] w_v_la;

    assign w_h_wrap = (pix.ctr_h == HW'(H_CNT - 1));
    assign w_v_wrap = (pix.ctr_v == VW'(V_CNT - 1));
    assign w_fb     = w_h_wrap && w_v_wrap;

    always_comb begin
        w_h_la = pix.ctr_h + HW'(1);
        w_v_la = pix.ctr_v;
        if (w_h_wrap) begin
            w_h_la = '0;
            w_v_la = w_v_wrap ? '0 : pix.ctr_v + VW'(1);
        end
    end

    logic          w_active;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;

    assign w_active = (int'(w_h_la) >= H_ADDR_START) &&
                      (int'(w_h_la) <  H_ADDR_START + VGA_WIDTH) &&
                      (int'(w_v_la) >= V_ADDR_START) &&
                      (int'(w_v_la) <  V_ADDR_START + VGA_HEIGHT);
    // Only meaningful while w_active; truncation keeps the in-range part.
    assign w_x = XW'(w_h_la - HW'(H_ADDR_START));
    assign w_y = YW'(w_v_la - VW'(V_ADDR_START));

    // ---------------------------------------------------------------
    // Box position (animated every frame regardless of mode)
    // ---------------------------------------------------------------
    logic [XW-1:0] w_bx;
    logic [YW-1:0] w_by;

    testpattern_gen_box #(
        .VGA_WIDTH  (VGA_WIDTH),
        .VGA_HEIGHT (VGA_HEIGHT),
        .BOX_SIZE   (BOX_SIZE)
    ) u_box (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_fb    (w_fb),
        .o_bx    (w_bx),
        .o_by    (w_by)
    );

    // ---------------------------------------------------------------
    // Mode FSM: a request is remembered in r_pending and applied at fb.
    // A request arriving on the fb cycle itself counts for the next fb.
    // ---------------------------------------------------------------
    mode_e r_mode;
    mode_e w_mode_nxt;
    logic  r_pending;
    logic  w_pending_nxt;
    logic  w_auto_wrap;

`ifdef TESTPATTERN_AUTO_CYCLE_EN
    localparam int AW = (AUTO_FRAMES > 1) ? tp_clog2(AUTO_FRAMES) : 1;
    logic [AW-1:0] r_auto_cnt;

    assign w_auto_wrap = w_fb && (r_auto_cnt == AW'(AUTO_FRAMES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_auto_cnt <= '0;
        else if (w_fb) r_auto_cnt <= w_auto_wrap ? '0 : r_auto_cnt + AW'(1);
    end
`else
    assign w_auto_wrap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= MODE_BARS;
            r_pending <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_mode_nxt    = r_mode;
        w_pending_nxt = r_pending | pix.mode_next;
        if (w_fb) begin
            if (r_pending) begin
                case (r_mode)
                    MODE_BARS:     w_mode_nxt = MODE_CHECKER;
                    MODE_CHECKER:  w_mode_nxt = MODE_GRADIENT;
                    MODE_GRADIENT: w_mode_nxt = MODE_BOX;
                    default:       w_mode_nxt = MODE_BARS;
                endcase
            end
            // Both request sources merge into one pending flag, so a
            // coincident pair still yields a single advance.
            w_pending_nxt = pix.mode_next | w_auto_wrap;
        end
    end

    // ---------------------------------------------------------------
    // Pattern mux
    // ---------------------------------------------------------------
    logic [2:0]             w_flags;
    logic                   w_chk;
    logic                   w_in_box;
    logic [COLOR_DEPTH-1:0] w_grad_r;
    logic [COLOR_DEPTH-1:0] w_grad_g;
    logic [COLOR_DEPTH-1:0] w_r;
    logic [COLOR_DEPTH-1:0] w_g;
    logic [COLOR_DEPTH-1:0] w_b;

    // The top three bits of x select one of the 8 equal-width bars.
    assign w_flags  = bar_flags(w_x[XW-1 -: 3]);
    assign w_chk    = w_x[5] ^ w_y[5];
    assign w_grad_r = COLOR_DEPTH'(w_x >> GRAD_SHIFT);
    assign w_grad_g = COLOR_DEPTH'(w_y >> GRAD_SHIFT);
    // Upper bounds in int: bx+box_size can reach vga_width, beyond XW bits.
    assign w_in_box = (w_x >= w_bx) && (int'(w_x) < int'(w_bx) + BOX_SIZE) &&
                      (w_y >= w_by) && (int'(w_y) < int'(w_by) + BOX_SIZE);

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_active) begin
            case (r_mode)
                MODE_BARS: begin
                    w_r = {COLOR_DEPTH{w_flags[2]}};
                    w_g = {COLOR_DEPTH{w_flags[1]}};
                    w_b = {COLOR_DEPTH{w_flags[0]}};
                end
                MODE_CHECKER: begin
                    w_r = {COLOR_DEPTH{w_chk}};
                    w_g = {COLOR_DEPTH{w_chk}};
                    w_b = {COLOR_DEPTH{w_chk}};
                end
                MODE_GRADIENT: begin
                    w_r = w_grad_r;
                    w_g = w_grad_g;
                    w_b = ~w_grad_r;
                end
                default: begin
                    if (w_in_box) begin
                        w_r = FULL;
                        w_g = FULL;
                        w_b = FULL;
                    end else begin
                        w_b = DARK_BLUE;
                    end
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Output registers and frame counter
    // ---------------------------------------------------------------
    logic [COLOR_DEPTH-1:0] r_r;
    logic [COLOR_DEPTH-1:0] r_g;
    logic [COLOR_DEPTH-1:0] r_b;
    logic [15:0]            r_frame_ctr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r         <= '0;
            r_g         <= '0;
            r_b         <= '0;
            r_frame_ctr <= '0;
        end else begin
            r_r <= w_r;
            r_g <= w_g;
            r_b <= w_b;
            if (w_fb) r_frame_ctr <= r_frame_ctr + 16'd1;
        end
    end

    assign pix.r_out     = r_r;
    assign pix.g_out     = r_g;
    assign pix.b_out     = r_b;
    assign pix.mode      = r_mode;
    assign pix.frame_ctr = r_frame_ctr;
endmodule

// File: tb/tb_testpattern_gen.sv
module tb_testpattern_gen;

    localparam int H_CNT = 1328;
    localparam int V_CNT = 806;
    localparam int H0    = 304;
    localparam int V0    = 38;
    localparam int W     = 1024;
    localparam int HGT   = 768;
    localparam int BOX   = 64;
    localparam int EXP_W = 42;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    testpattern_gen_if #(.CTR_H_W(11), .CTR_V_W(10), .COLOR_DEPTH(8)) pix ();

    testpattern_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pix   (pix)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode, m_pending, m_frame, m_bx, m_by, m_dx, m_dy, m_auto;
    int bar_r[8] = '{255, 255,   0,   0, 255, 255,   0, 0};
    int bar_g[8] = '{255, 255, 255, 255,   0,   0,   0, 0};
    int bar_b[8] = '{255,   0, 255,   0, 255,   0, 255, 0};

    task automatic model_reset();
        m_mode = 0; m_pending = 0; m_frame = 0;
        m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_auto = 0;
    endtask

    // Colour the driver shows next cycle when its counters are (h,v) now.
    function automatic logic [23:0] ref_pixel(input int h, input int v);
        int hn, vn, x, y, r, g, b;
        hn = h + 1; vn = v;
        if (hn == H_CNT) begin
            hn = 0; vn = v + 1;
            if (vn == V_CNT) vn = 0;
        end
        x = hn - H0; y = vn - V0;
        r = 0; g = 0; b = 0;
        if (x >= 0 && x < W && y >= 0 && y < HGT) begin
            if (m_mode == 0) begin
                r = bar_r[x / (W / 8)]; g = bar_g[x / (W / 8)]; b = bar_b[x / (W / 8)];
            end else if (m_mode == 1) begin
                if (((x / 32) % 2) != ((y / 32) % 2)) begin r = 255; g = 255; b = 255; end
            end else if (m_mode == 2) begin
                r = x / 4; g = y / 4; b = 255 - r;
            end else begin
                if (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) begin
                    r = 255; g = 255; b = 255;
                end else begin
                    b = 255 / 4;
                end
            end
        end
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic model_step(input int h, input int v, input bit mn);
        bit wrap;
        wrap = 1'b0;
        if (h == H_CNT - 1 && v == V_CNT - 1) begin
            m_frame = (m_frame + 1) % 65536;
            if (m_pending != 0) m_mode = (m_mode + 1) % 4;
`ifdef TESTPATTERN_AUTO_CYCLE_EN
            wrap = (m_auto == 119);
            m_auto = wrap ? 0 : m_auto + 1;
`endif
            m_pending = (mn || wrap) ? 1 : 0;
            if (m_dx == 1 && m_bx == W - BOX)  m_dx = -1;
            else if (m_dx == -1 && m_bx == 0)  m_dx = 1;
            else                               m_bx = m_bx + m_dx;
            if (m_dy == 1 && m_by == HGT - BOX) m_dy = -1;
            else if (m_dy == -1 && m_by == 0)   m_dy = 1;
            else                                m_by = m_by + m_dy;
        end else if (mn) begin
            m_pending = 1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_cycle();
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check_eq("r_out",     32'(pix.r_out),     32'(e[41:34]));
        check_eq("g_out",     32'(pix.g_out),     32'(e[33:26]));
        check_eq("b_out",     32'(pix.b_out),     32'(e[25:18]));
        check_eq("mode",      32'(pix.mode),      32'(e[17:16]));
        check_eq("frame_ctr", 32'(pix.frame_ctr), 32'(e[15:0]));
    endtask

    task automatic run_cycle(input int h, input int v, input bit mn);
        logic [23:0] px;
        px = ref_pixel(h, v);
        pix.ctr_h     = 11'(h);
        pix.ctr_v     = 10'(v);
        pix.mode_next = mn;
        model_step(h, v, mn);
        exp_q.push_back({px, 2'(m_mode), 16'(m_frame)});
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic run_fb(input bit mn);
        run_cycle(H_CNT - 1, V_CNT - 1, mn);
    endtask

    // Random position whose lookahead lands inside the active area.
    task automatic run_active(input bit mn);
        run_cycle(int'($urandom_range(0, W - 1)) + H0 - 1, int'($urandom_range(0, HGT - 1)) + V0, mn);
    endtask

    task automatic run_any(input bit mn);
        run_cycle(int'($urandom_range(0, H_CNT - 1)), int'($urandom_range(0, V_CNT - 1)), mn);
    endtask

    // Position near the current box so its edges get exercised.
    task automatic run_near_box();
        int x, y;
        x = m_bx + int'($urandom_range(0, BOX + 3)) - 2;
        y = m_by + int'($urandom_range(0, BOX + 3)) - 2;
        if (x < 0) x = 0;
        if (x > W - 1) x = W - 1;
        if (y < 0) y = 0;
        if (y > HGT - 1) y = HGT - 1;
        run_cycle(x + H0 - 1, y + V0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_r"},     32'(pix.r_out),     32'd0);
        check_eq({tag, "_g"},     32'(pix.g_out),     32'd0);
        check_eq({tag, "_b"},     32'(pix.b_out),     32'd0);
        check_eq({tag, "_mode"},  32'(pix.mode),      32'd0);
        check_eq({tag, "_frame"}, 32'(pix.frame_ctr), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        pix.ctr_h = '0;
        pix.ctr_v = '0;
        pix.mode_next = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // Directed pixels in BARS, including the wrap into blanking.
        run_cycle(303, 38, 1'b0);
        run_cycle(431, 100, 1'b0);
        run_cycle(H_CNT - 1, V_CNT - 1, 1'b0);
        for (int i = 0; i < 60; i++) run_any(1'b0);

        // Three requests in one frame give one advance at fb.
        for (int p = 0; p < 3; p++) begin
            run_active(1'b1);
            for (int i = 0; i < 5; i++) run_active(1'b0);
        end
        run_fb(1'b0);
        for (int i = 0; i < 40; i++) run_active(1'b0);
        // Request on the fb cycle counts for the following fb.
        run_fb(1'b1);
        for (int i = 0; i < 20; i++) run_active(1'b0);
        run_fb(1'b0);
        for (int i = 0; i < 40; i++) run_active(1'b0);

        // Asynchronous reset mid-line while in GRADIENT.
        run_cycle(800, 400, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Mixed random traffic across all modes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) run_fb($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 1) == 0) run_any($urandom_range(0, 24) == 0);
            else run_active($urandom_range(0, 24) == 0);
        end

        // Box bounce: fresh start, move to BOX, then run ~980 frames.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            run_active(1'b1);
            run_fb(1'b0);
        end
        for (int f = 0; f < 980; f++) begin
            run_fb(1'b0);
            for (int i = 0; i < 3; i++) run_near_box();
        end
        for (int i = 0; i < 100; i++) run_any($urandom_range(0, 30) == 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
